// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter: event kind encoding,
// the event record and the round-robin index wrap.
package edge_evt_pkg;

    localparam int EVT_CH_MAX_W = 8;

    typedef enum logic {
        EVT_RISE = 1'b0,
        EVT_FALL = 1'b1
    } evt_type_e;

    typedef struct packed {
        logic [EVT_CH_MAX_W-1:0] ch;
        evt_type_e               kind;
    } evt_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int W = $clog2(N);

    int           idx;
    logic [W-1:0] idx_w;

    // Scan offsets from farthest to nearest so the closest request is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (req[idx_w]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_w;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge detector with per-channel rise/fall pending bits, sticky overflow
// flags and a round-robin serialiser onto one valid/ready event port.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         a_i,
    input  logic [NUM_CH-1:0]         en_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
    output logic                      evt_fall_o,
    output logic [NUM_CH-1:0]         overflow_o,
    input  logic [NUM_CH-1:0]         clear_ovf_i,
    output logic                      pend_any_o
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] prev_reg;
    logic [NUM_CH-1:0] pend_r_reg, pend_r_next;
    logic [NUM_CH-1:0] pend_f_reg, pend_f_next;
    logic [NUM_CH-1:0] order_reg, order_next;
    logic [NUM_CH-1:0] ovf_reg, ovf_next;
    logic [CH_W-1:0]   ptr_reg;
    logic              valid_reg;
    logic [CH_W-1:0]   ch_reg;
    evt_type_e         kind_reg;

    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;
    evt_type_e         gnt_kind;
    logic              load;
    logic              take;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_rr_arbiter (
        .req       (pend_r_reg | pend_f_reg),
        .ptr       (ptr_reg),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Older type first when both are pending; order bit set means the fall is older.
    always_comb begin
        gnt_kind = EVT_RISE;
        if (pend_f_reg[gnt_idx] && (!pend_r_reg[gnt_idx] || order_reg[gnt_idx])) begin
            gnt_kind = EVT_FALL;
        end
    end

    assign load = !valid_reg || evt_ready_i;
    assign take = load && gnt_valid;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic rise, fall, hit, clr_r, clr_f, r_old, f_old;

            assign rise  = a_i[gi] & ~prev_reg[gi];
            assign fall  = ~a_i[gi] & prev_reg[gi];
            assign hit   = take && (gnt_idx == CH_W'(gi));
            assign clr_r = hit && (gnt_kind == EVT_RISE);
            assign clr_f = hit && (gnt_kind == EVT_FALL);
            // An already-pending bit that is not being handed to the output this cycle.
            assign r_old = pend_r_reg[gi] & ~clr_r;
            assign f_old = pend_f_reg[gi] & ~clr_f;

            assign pend_r_next[gi] = en_i[gi] & (rise | r_old);
            assign pend_f_next[gi] = en_i[gi] & (fall | f_old);
            assign ovf_next[gi]    = (en_i[gi] & ((rise & r_old) | (fall & f_old)))
                                   | (ovf_reg[gi] & ~clear_ovf_i[gi]);
            assign order_next[gi]  = pend_r_next[gi] & pend_f_next[gi]
                                   & ((r_old & f_old) ? order_reg[gi] : f_old);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg   <= '0;
            pend_r_reg <= '0;
            pend_f_reg <= '0;
            order_reg  <= '0;
            ovf_reg    <= '0;
            ptr_reg    <= '0;
            valid_reg  <= 1'b0;
            ch_reg     <= '0;
            kind_reg   <= EVT_RISE;
        end else begin
            prev_reg   <= a_i;
            pend_r_reg <= pend_r_next;
            pend_f_reg <= pend_f_next;
            order_reg  <= order_next;
            ovf_reg    <= ovf_next;
            if (load) begin
                if (gnt_valid) begin
                    valid_reg <= 1'b1;
                    ch_reg    <= gnt_idx;
                    kind_reg  <= gnt_kind;
                    ptr_reg   <= CH_W'(wrap_inc(int'(gnt_idx), NUM_CH));
                end else begin
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign evt_valid_o = valid_reg;
    assign evt_ch_o    = ch_reg;
    assign evt_fall_o  = (kind_reg == EVT_FALL);
    assign overflow_o  = ovf_reg;
    assign pend_any_o  = |(pend_r_reg | pend_f_reg);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: latency, round-robin wrap, hold and
// overflow, type ordering, enable gating and asynchronous reset.
module tb_edge_event_arbiter;
    import edge_evt_pkg::*;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH-1:0] a_i = '0;
    logic [NUM_CH-1:0] en_i = '1;
    logic [NUM_CH-1:0] clear_ovf_i = '0;
    logic              evt_ready_i = 1'b1;
    logic              evt_valid_o;
    logic [1:0]        evt_ch_o;
    logic              evt_fall_o;
    logic [NUM_CH-1:0] overflow_o;
    logic              pend_any_o;

    int tests_run = 0;
    int tests_failed = 0;

    evt_t t4_exp [6];

    edge_event_arbiter #(
        .NUM_CH(NUM_CH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_i         (a_i),
        .en_i        (en_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_fall_o  (evt_fall_o),
        .overflow_o  (overflow_o),
        .clear_ovf_i (clear_ovf_i),
        .pend_any_o  (pend_any_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input string tag, input int ch, input int fall);
        check_val({tag, ".valid"}, int'(evt_valid_o), 1);
        check_val({tag, ".ch"}, int'(evt_ch_o), ch);
        check_val({tag, ".fall"}, int'(evt_fall_o), fall);
        $display("[TB] %s: event ch=%0d fall=%0d", tag, evt_ch_o, evt_fall_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t4_exp[0] = '{ch: 8'd1, kind: EVT_RISE};
        t4_exp[1] = '{ch: 8'd3, kind: EVT_RISE};
        t4_exp[2] = '{ch: 8'd0, kind: EVT_FALL};
        t4_exp[3] = '{ch: 8'd1, kind: EVT_FALL};
        t4_exp[4] = '{ch: 8'd3, kind: EVT_FALL};
        t4_exp[5] = '{ch: 8'd0, kind: EVT_RISE};

        // Reset state
        repeat (2) tick();
        check_val("rst.valid", int'(evt_valid_o), 0);
        check_val("rst.ch", int'(evt_ch_o), 0);
        check_val("rst.fall", int'(evt_fall_o), 0);
        check_val("rst.ovf", int'(overflow_o), 0);
        check_val("rst.pend", int'(pend_any_o), 0);
        reset = 1'b1;

        // 1: single rise, two-cycle latency, one-cycle pulse
        a_i = 4'b0100;
        tick();
        check_val("t1.e0.valid", int'(evt_valid_o), 0);
        check_val("t1.e0.pend", int'(pend_any_o), 1);
        tick();
        expect_evt("t1", 2, 0);
        check_val("t1.pend_clr", int'(pend_any_o), 0);
        tick();
        check_val("t1.drop", int'(evt_valid_o), 0);

        // 2: four simultaneous rises then falls, pointer starts at 0 and wraps
        reset = 1'b0;
        a_i = 4'b0000;
        #1;
        reset = 1'b1;
        a_i = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_evt($sformatf("t2.rise%0d", k), k, 0);
        end
        tick();
        check_val("t2.idle1", int'(evt_valid_o), 0);
        a_i = 4'b0000;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_evt($sformatf("t2.fall%0d", k), k, 1);
        end
        tick();
        check_val("t2.idle2", int'(evt_valid_o), 0);

        // 3: output held under backpressure, overflow and its clear
        evt_ready_i = 1'b0;
        a_i = 4'b0001;
        tick();
        tick();
        expect_evt("t3.hold", 0, 0);
        a_i = 4'b0011;
        tick();
        a_i = 4'b0001;
        tick();
        a_i = 4'b0011;
        tick();
        check_val("t3.ovf_set", int'(overflow_o), 2);
        expect_evt("t3.stable", 0, 0);
        clear_ovf_i = 4'b0010;
        tick();
        clear_ovf_i = 4'b0000;
        check_val("t3.ovf_clr", int'(overflow_o), 0);

        // 4: rise-older on ch3, fall-older on ch0, drained in round-robin order
        a_i = 4'b1011;
        tick();
        a_i = 4'b0011;
        tick();
        a_i = 4'b0010;
        tick();
        a_i = 4'b0011;
        tick();
        check_val("t4.pend", int'(pend_any_o), 1);
        check_val("t4.ovf", int'(overflow_o), 0);
        expect_evt("t4.held", 0, 0);
        evt_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_evt($sformatf("t4.ev%0d", k), int'(t4_exp[k].ch),
                       (t4_exp[k].kind == EVT_FALL) ? 1 : 0);
        end
        tick();
        check_val("t4.idle", int'(evt_valid_o), 0);
        check_val("t4.pend_clr", int'(pend_any_o), 0);

        // 5: disabling clears pending and ignores edges; re-enable reports only new edges
        evt_ready_i = 1'b0;
        a_i = 4'b0111;
        tick();
        tick();
        expect_evt("t5.blk", 2, 0);
        a_i = 4'b0101;
        tick();
        a_i = 4'b0111;
        tick();
        check_val("t5.pend_set", int'(pend_any_o), 1);
        en_i = 4'b1101;
        tick();
        check_val("t5.pend_dis", int'(pend_any_o), 0);
        a_i = 4'b0101;
        tick();
        a_i = 4'b0111;
        tick();
        check_val("t5.pend_ign", int'(pend_any_o), 0);
        check_val("t5.ovf", int'(overflow_o), 0);
        en_i = 4'b1111;
        evt_ready_i = 1'b1;
        tick();
        check_val("t5.no_ch1", int'(evt_valid_o), 0);
        a_i = 4'b0101;
        tick();
        check_val("t5.new_pend", int'(pend_any_o), 1);
        tick();
        expect_evt("t5.new", 1, 1);
        tick();
        check_val("t5.idle", int'(evt_valid_o), 0);

        // 6: asynchronous reset mid-transfer
        evt_ready_i = 1'b0;
        a_i = 4'b1101;
        tick();
        tick();
        expect_evt("t6.pre", 3, 0);
        a_i = 4'b1111;
        tick();
        a_i = 4'b1101;
        tick();
        a_i = 4'b1111;
        tick();
        check_val("t6.pre_ovf", int'(overflow_o), 2);
        check_val("t6.pre_pend", int'(pend_any_o), 1);
        #2;
        reset = 1'b0;
        a_i = 4'b0001;
        #1;
        check_val("t6.async.valid", int'(evt_valid_o), 0);
        check_val("t6.async.ch", int'(evt_ch_o), 0);
        check_val("t6.async.fall", int'(evt_fall_o), 0);
        check_val("t6.async.pend", int'(pend_any_o), 0);
        check_val("t6.async.ovf", int'(overflow_o), 0);
        tick();
        reset = 1'b1;
        evt_ready_i = 1'b1;
        tick();
        check_val("t6.post.valid0", int'(evt_valid_o), 0);
        check_val("t6.post.pend", int'(pend_any_o), 1);
        tick();
        expect_evt("t6.post", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
